// File: rtl/div_issue_queue.sv
// Tagged request FIFO feeding a combinational 16/8 divider, with one registered
// result slot held until the consumer accepts it.
module div_issue_queue #(
  parameter int DEPTH = 4,
  parameter int TAG_W = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [15:0]      in_a,
  input  logic [7:0]       in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic [15:0]      div_a,
  output logic [7:0]       div_b,
  input  logic [15:0]      div_result,
  input  logic [15:0]      div_odd,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [15:0]      out_result,
  output logic [15:0]      out_odd,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_dbz,
  output logic [CW-1:0]    count
);

  logic [15:0]      mem_a   [DEPTH];
  logic [7:0]       mem_b   [DEPTH];
  logic [TAG_W-1:0] mem_tag [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          not_empty;
  logic          push;
  logic          issue;

  assign not_empty = (count != '0);
  // Readiness looks only at occupancy, so a full queue refuses even while popping.
  assign in_ready  = (count < CW'(DEPTH));
  assign push      = in_valid & in_ready;
  assign issue     = not_empty & (~out_valid | out_ready);

  assign div_a = not_empty ? mem_a[rd_ptr] : 16'd0;
  assign div_b = not_empty ? mem_b[rd_ptr] : 8'd0;

  // Storage needs no reset; emptiness is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_a[wr_ptr]   <= in_a;
      mem_b[wr_ptr]   <= in_b;
      mem_tag[wr_ptr] <= in_tag;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      out_valid  <= 1'b0;
      out_result <= '0;
      out_odd    <= '0;
      out_tag    <= '0;
      out_dbz    <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
      end

      if (issue) begin
        rd_ptr     <= rd_ptr + PW'(1);
        out_result <= div_result;
        out_odd    <= div_odd;
        out_tag    <= mem_tag[rd_ptr];
        out_dbz    <= (mem_b[rd_ptr] == 8'd0);
        out_valid  <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      case ({push, issue})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_div_issue_queue.sv
// Bench for div_issue_queue: directed vectors and corner sequences, then random
// traffic against a queue-based reference model.
module tb_div_issue_queue;

  localparam int DEPTH = 4;
  localparam int TAG_W = 4;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic             clk;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [7:0]       in_b;
  logic [TAG_W-1:0] in_tag;
  logic [15:0]      div_a;
  logic [7:0]       div_b;
  logic [15:0]      div_result;
  logic [15:0]      div_odd;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_result;
  logic [15:0]      out_odd;
  logic [TAG_W-1:0] out_tag;
  logic             out_dbz;
  logic [CW-1:0]    count;

  int total = 0;
  int bad   = 0;

  div_issue_queue #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_tag(in_tag),
    .div_a(div_a), .div_b(div_b),
    .div_result(div_result), .div_odd(div_odd),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_odd(out_odd),
    .out_tag(out_tag), .out_dbz(out_dbz),
    .count(count)
  );

  // Divider stand-in: zero divisor yields all-ones quotient and the dividend as remainder.
  assign div_result = (div_b == 8'd0) ? 16'hFFFF : div_a / {8'd0, div_b};
  assign div_odd    = (div_b == 8'd0) ? div_a    : div_a % {8'd0, div_b};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0]      a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
    logic [15:0]      q;
    logic [15:0]      r;
    logic             dbz;
  } vec_t;

  typedef struct {
    logic [15:0]      a;
    logic [7:0]       b;
    logic [TAG_W-1:0] tag;
  } req_t;

  vec_t vecs [6];
  req_t exp_q [$];
  bit   m_ov;
  logic [TAG_W-1:0] tag_ctr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [15:0] a, input logic [7:0] b,
                       input logic [TAG_W-1:0] t);
    in_valid = v;
    in_a     = a;
    in_b     = b;
    in_tag   = t;
  endtask

  // Reference: exp_q holds every accepted request not yet consumed; m_ov says
  // whether its head currently sits in the output slot.
  task automatic sb_cycle(input bit iv, input bit ordy);
    int fifo_n;
    bit m_push, m_issue, hold;
    logic [15:0] q, r, s_res, s_odd;
    logic [TAG_W-1:0] s_tag;
    logic s_dbz;
    req_t h, n;
    out_ready = ordy;
    drive(iv, 16'($urandom), ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom), tag_ctr);
    fifo_n = exp_q.size() - int'(m_ov);
    chk("sb_in_ready", in_ready, fifo_n < DEPTH);
    m_push  = iv && (fifo_n < DEPTH);
    m_issue = (fifo_n > 0) && (!m_ov || ordy);
    hold    = m_ov && !ordy;
    s_res = out_result; s_odd = out_odd; s_tag = out_tag; s_dbz = out_dbz;
    if (m_ov && ordy) begin
      h = exp_q.pop_front();
      q = (h.b == 0) ? 16'hFFFF : h.a / h.b;
      r = (h.b == 0) ? h.a      : h.a % h.b;
      chk("sb_tag", out_tag, h.tag);
      chk("sb_result", out_result, q);
      chk("sb_odd", out_odd, r);
      chk("sb_dbz", out_dbz, h.b == 0);
    end
    if (m_push) begin
      n.a = in_a; n.b = in_b; n.tag = in_tag;
      exp_q.push_back(n);
      tag_ctr = tag_ctr + 1'b1;
    end
    m_ov = hold || m_issue;
    step();
    chk("sb_out_valid", out_valid, m_ov);
    chk("sb_count", count, exp_q.size() - int'(m_ov));
    if (hold) begin
      chk("sb_hold", {out_dbz, out_tag, out_odd, out_result}, {s_dbz, s_tag, s_odd, s_res});
    end
  endtask

  initial begin
    vecs[0] = '{16'd1000,   8'd7,   4'd3, 16'd142,   16'd6,      1'b0};
    vecs[1] = '{16'h1234,   8'd0,   4'd5, 16'hFFFF,  16'h1234,   1'b1};
    vecs[2] = '{16'd65535,  8'd255, 4'd1, 16'd257,   16'd0,      1'b0};
    vecs[3] = '{16'd100,    8'd3,   4'd2, 16'd33,    16'd1,      1'b0};
    vecs[4] = '{16'd5,      8'd9,   4'd4, 16'd0,     16'd5,      1'b0};
    vecs[5] = '{16'd255,    8'd16,  4'd6, 16'd15,    16'd15,     1'b0};

    rst = 1'b1;
    out_ready = 1'b0;
    drive(1'b0, 16'd0, 8'd0, 4'd0);
    #2;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_count", count, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_div_ab", {div_a, div_b}, 0);
    chk("rst_out_regs", {out_dbz, out_tag, out_odd, out_result}, 0);
    step();
    step();
    rst = 1'b0;

    // Single requests: accept at edge k, result visible from edge k+1.
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, vecs[i].a, vecs[i].b, vecs[i].tag);
      step();
      drive(1'b0, 16'd0, 8'd0, 4'd0);
      chk("vec_count1", count, 1);
      chk("vec_no_bypass", out_valid, 0);
      chk("vec_div_a", div_a, vecs[i].a);
      step();
      chk("vec_out_valid", out_valid, 1);
      chk("vec_result", out_result, vecs[i].q);
      chk("vec_odd", out_odd, vecs[i].r);
      chk("vec_tag", out_tag, vecs[i].tag);
      chk("vec_dbz", out_dbz, vecs[i].dbz);
      chk("vec_count0", count, 0);
      step();
      chk("vec_drained", out_valid, 0);
    end

    // Backpressure: fill to DEPTH behind a held result.
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 16'(100 + i), 8'(i + 1), 4'(i));
      step();
    end
    drive(1'b0, 16'd0, 8'd0, 4'd0);
    chk("bp_count_full", count, DEPTH);
    chk("bp_in_ready", in_ready, 0);
    chk("bp_tag0", out_tag, 0);
    chk("bp_res0", out_result, 16'd100);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("bp_hold_tag", out_tag, 0);
      chk("bp_hold_valid", out_valid, 1);
      chk("bp_hold_count", count, DEPTH);
    end
    out_ready = 1'b1;
    drive(1'b1, 16'd7, 8'd7, 4'd15);
    chk("full_pop_in_ready", in_ready, 0);
    step();
    drive(1'b0, 16'd0, 8'd0, 4'd0);
    chk("full_refused_count", count, DEPTH - 1);
    chk("full_in_ready_next", in_ready, 1);
    for (int i = 1; i < 5; i++) begin
      chk("bp_order_tag", out_tag, i);
      chk("bp_order_res", out_result, 16'((100 + i) / (i + 1)));
      chk("bp_order_valid", out_valid, 1);
      step();
    end
    chk("bp_end_valid", out_valid, 0);
    chk("bp_end_count", count, 0);

    // Push and pop together at count=2.
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 16'(200 + i), 8'd10, 4'(10 + i));
      step();
    end
    chk("pp_count_pre", count, 2);
    chk("pp_tag_pre", out_tag, 10);
    drive(1'b1, 16'd230, 8'd10, 4'd13);
    out_ready = 1'b1;
    step();
    drive(1'b0, 16'd0, 8'd0, 4'd0);
    chk("pp_count_same", count, 2);
    chk("pp_tag11", out_tag, 11);
    step();
    chk("pp_tag12", out_tag, 12);
    chk("pp_count1", count, 1);
    step();
    chk("pp_tag13", out_tag, 13);
    chk("pp_res13", out_result, 16'd23);
    step();
    chk("pp_end_valid", out_valid, 0);

    // Reset mid-stream with queued and held results.
    out_ready = 1'b0;
    for (int i = 1; i < 5; i++) begin
      drive(1'b1, 16'd77, 8'd3, 4'(i));
      step();
    end
    drive(1'b0, 16'd0, 8'd0, 4'd0);
    chk("mr_count_pre", count, 3);
    chk("mr_valid_pre", out_valid, 1);
    #2;
    rst = 1'b1;
    #1;
    chk("mr_count", count, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_in_ready", in_ready, 1);
    chk("mr_tag", out_tag, 0);
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    drive(1'b1, 16'd50, 8'd5, 4'd9);
    step();
    drive(1'b0, 16'd0, 8'd0, 4'd0);
    chk("mr_first_count", count, 1);
    step();
    chk("mr_first_valid", out_valid, 1);
    chk("mr_first_tag", out_tag, 9);
    chk("mr_first_res", out_result, 16'd10);
    step();
    chk("mr_end_valid", out_valid, 0);

    // Random traffic against the reference model.
    m_ov = 1'b0;
    tag_ctr = '0;
    for (int i = 0; i < 400; i++) begin
      sb_cycle($urandom_range(0, 99) < 60, $urandom_range(0, 99) < 55);
    end
    for (int i = 0; i < 20 && exp_q.size() > 0; i++) sb_cycle(1'b0, 1'b1);
    chk("rand_drained", exp_q.size(), 0);

    // Streaming: one result per cycle, occupancy never above 1.
    for (int i = 0; i < 20; i++) begin
      sb_cycle(1'b1, 1'b1);
      chk("stream_count_le1", count <= 1, 1);
      if (i > 0) chk("stream_valid", out_valid, 1);
    end
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) sb_cycle(1'b0, 1'b1);
    chk("stream_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/div_issue_queue.md
Name: div_issue_queue

Overview:
- Request buffer and issue stage around the combinational 16-bit by 8-bit divider (`div_16bit`).
- Accepts tagged divide requests over a valid/ready interface and queues them in a DEPTH-entry FIFO.
- Presents the FIFO head operands to the divider, registers the divider outputs with the request's tag, and holds them until the downstream consumer accepts.

Parameters:
- DEPTH, 4, FIFO entries; power of two, at least 2.
- TAG_W, 4, width of the request tag carried alongside the operands.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  request present.
- in_ready  out  1  queue can accept; equals (count < DEPTH).
- in_a  in  16  dividend.
- in_b  in  8  divisor.
- in_tag  in  TAG_W  request tag.
- div_a  out  16  dividend to the divider; FIFO head, 0 when empty.
- div_b  out  8  divisor to the divider; FIFO head, 0 when empty.
- div_result  in  16  quotient returned by the divider (combinational from div_a/div_b).
- div_odd  in  16  remainder returned by the divider.
- out_valid  out  1  registered result present.
- out_ready  in  1  consumer accepts the result.
- out_result  out  16  registered quotient.
- out_odd  out  16  registered remainder.
- out_tag  out  TAG_W  tag of the registered result.
- out_dbz  out  1  registered flag: divisor of that request was 0.
- count  out  clog2(DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (asynchronous, active-high):
  - read/write pointers, count, out_valid, out_result, out_odd, out_tag and out_dbz all go to 0.
  - in_ready therefore reads 1 while reset is held; div_a and div_b read 0.
- push = in_valid & in_ready.
  - Writes {in_a, in_b, in_tag} at the write pointer.
  - Write pointer wraps modulo DEPTH.
- in_ready depends only on count, never on a same-cycle pop: a full FIFO refuses a request even while it is popping.
- issue = (count != 0) & (!out_valid | out_ready). On issue:
  - head entry is popped;
  - out_result <= div_result, out_odd <= div_odd, out_tag <= head tag, out_dbz <= (head b == 0);
  - out_valid <= 1.
- If out_valid & out_ready and the FIFO is empty, out_valid <= 0. Output data registers keep their last values.
- Output hold: while out_valid & !out_ready, all out_* signals are stable and no issue occurs.
- Count update:
  - push only: +1.
  - issue only: -1.
  - push and issue together on a non-empty FIFO: count unchanged.
  - push into an empty FIFO: no same-cycle issue, because there is no bypass.
- Latency:
  - A request accepted at edge k can issue at edge k+1 at the earliest; out_valid is then high from k+1.
  - Sustained throughput is one result per cycle while out_ready is held at 1.
- Ordering: strictly FIFO; out_tag order equals the acceptance order.
- Divide by zero: the divider outputs are passed through unmodified; the only added behaviour is setting out_dbz.
- Full/empty: count never exceeds DEPTH and never underflows. Pointer wrap-around is transparent to ordering.
- Reset mid-operation: all queued and held results are discarded with no partial output. The first request after reset sees an empty queue.

Test Plan:
- Single request a=1000, b=7, tag=3 with out_ready=1 → out_valid is high one cycle after acceptance with out_result=142, out_odd=6, out_tag=3, out_dbz=0. The bench drives div_result/div_odd from a quotient/remainder model.
- Divide by zero: a=0x1234, b=0, tag=5 → out_dbz=1, out_tag=5, out_result/out_odd equal the model's zero-divisor outputs.
- Backpressure: out_ready=0, push 5 requests (tags 0..4) → first issues; 4 then fill the FIFO; count=4, in_ready=0, outputs stable on tag 0. Raise out_ready → tags emerge 0,1,2,3,4 on consecutive cycles.
- Streaming: in_valid=1 and out_ready=1 for 20 cycles with random operands → count stays ≤1, one result per cycle, all tags in order, and pointers wrap several times.
- Simultaneous push and pop at count=2 → count stays 2, no data lost. At count=DEPTH with out_ready=1 → in_ready=0 that cycle, then 1 the next.
- Assert rst mid-stream with count=3 and out_valid=1 → immediately count=0, out_valid=0, in_ready=1. Next request tag=9 emerges as the first output.
